// File: rtl/a_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : a_input_debounce
// Purpose  : Conditions a raw, asynchronous, bouncing push-button/switch into
//            a clean clock-synchronous control level A for the downstream
//            Y2..Y0 state machine (Ej62). Also provides one-cycle edge pulses
//            and a busy flag.
//            Structure: 2-flop synchronizer -> 4-state debounce FSM with a
//            stability counter.
// Ports    : clck  in  system clock, rising-edge active
//            rst   in  synchronous reset, active-high
//            btn   in  raw asynchronous button input (may bounce)
//            A     out clean control level (level or toggle, see TOGGLE)
//            rise  out one-cycle pulse, debounced level went 0->1
//            fall  out one-cycle pulse, debounced level went 1->0
//            busy  out high while a level change is being qualified
// Params   : STABLE_CYC  cycles the synchronized input must stay constant
//                        (legal range 2 .. 2**CNT_W-1)
//            CNT_W       stability counter width
//            TOGGLE      0: A = debounced level, 1: A inverts on each press
// Revision : 1.0  initial release
// ============================================================================
module a_input_debounce #(
    parameter int STABLE_CYC = 10,
    parameter int CNT_W      = 4,
    parameter bit TOGGLE     = 1'b0
) (
    input  logic clck,
    input  logic rst,
    input  logic btn,
    output logic A,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             db;
    logic             db_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // ------------------------------------------------------------------
    // Synchronizer: btn is asynchronous, only s2 is used downstream.
    // ------------------------------------------------------------------
    always_ff @(posedge clck) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // State register (also holds counter, debounced level and pulses so
    // that they all update on the same edge as the state).
    // ------------------------------------------------------------------
    always_ff @(posedge clck) begin
        if (rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db    <= db_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The reversion test comes before the terminal-count
    // test, so the input must still be stable on the deciding cycle.
    // The counter is held (not cleared) outside the WAIT states; it is
    // cleared on entry to a WAIT state instead.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s2) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_nxt = IDLE_LO;
                end else if (cnt == CNT_TERM) begin
                    state_nxt = IDLE_HI;
                    db_nxt    = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_nxt = IDLE_HI;
                end else if (cnt == CNT_TERM) begin
                    state_nxt = IDLE_LO;
                    db_nxt    = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: busy decodes the registered state directly.
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state == WAIT_HI) || (state == WAIT_LO);
    end

    // ------------------------------------------------------------------
    // A output: plain level, or a toggle flop advanced on each accepted
    // press (same edge as rise, releases ignored).
    // ------------------------------------------------------------------
    generate
        if (TOGGLE) begin : g_toggle
            logic a_tgl;
            always_ff @(posedge clck) begin
                if (rst) begin
                    a_tgl <= 1'b0;
                end else if (rise_nxt) begin
                    a_tgl <= ~a_tgl;
                end
            end
            assign A = a_tgl;
        end else begin : g_level
            assign A = db;
        end
    endgenerate

endmodule
`default_nettype wire
